uart_tx_queue: RTL

//  Transmit scheduler between the CPU IO page and the UART byte emitter. Buffers
//  CPU byte writes in a FIFO, feeds the emitter one byte at a time over its

---
 rtl/uart_tx_queue.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// UART transmit queue: byte FIFO feeding the emitter over valid/ready.
// Ports: clk, resetn (sync, active-low), wr_en/wr_data (CPU byte write),
//   clr_ovf (clear sticky overflow), tx_data/tx_valid/tx_ready (emitter),
//   st_count/st_full/st_empty/st_busy/st_overflow (polled status word).
// Optional build macro UART_TX_CRLF_EN: a queued 0x0A goes out as 0x0D, 0x0A.
module uart_tx_queue #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [AW:0]   st_count,
  output logic          st_full,
  output logic          st_empty,
  output logic          st_busy,
  output logic          st_overflow
);

`ifdef UART_TX_CRLF_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    SEND_CR = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          ovf_q, ovf_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A full FIFO still takes a write when the scheduler pops that cycle.
  assign push = wr_en & (~full | pop);

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = head;
          state_d    = SEND;
`ifdef UART_TX_CRLF_EN
          if (head == 8'h0A) begin
            tx_data_d = 8'h0D;
            state_d   = SEND_CR;
          end
`endif
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
`ifdef UART_TX_CRLF_EN
      SEND_CR: begin
        // CR accepted: present the LF without a bubble or a second pop.
        if (tx_ready) begin
          tx_data_d = 8'h0A;
          state_d   = SEND;
        end
      end
`endif
      default: begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A dropped write outranks a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (wr_en && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign st_count    = count_q;
  assign st_full     = full;
  assign st_empty    = empty;
  assign st_busy     = ~empty | tx_valid_q | ~tx_ready;
  assign st_overflow = ovf_q;

endmodule
